// File: rtl/serial_seq_pkg.sv
// serial_seq_pkg
// Shared types and helpers for the serial sequence generator.
//   state_t  : transmitter FSM states
//   REPS_W   : width of the repetition count
//   cnt_w    : clog2-based counter width (minimum 1 bit)
//   frame_len: bits per repetition; one extra parity bit when
//              SERIAL_SEQ_PARITY_EN is defined
package serial_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int REPS_W = 8;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_len(input int width);
`ifdef SERIAL_SEQ_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/serial_seq_shifter.sv
// serial_seq_shifter
// Pattern register plus MSB-first shift register. The shift register
// always holds the bits still to be sent *after* the one currently on
// the serial line, so loads store the frame already shifted by one.
// With SERIAL_SEQ_PARITY_EN defined the frame carries an even-parity
// tap (XOR of the pattern) in its LSB.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : latch data into pattern and shift registers
//   reload   : restart the frame from the pattern register
//   shift    : advance the shift register by one bit
//   data     : pattern word
//   pat_msb  : first bit of the stored pattern
//   cur_bit  : next bit to be sent
module serial_seq_shifter
  import serial_seq_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             pat_msb,
  output logic             cur_bit
);

  localparam int FRAME = frame_len(WIDTH);

  logic [WIDTH-1:0] pat;
  logic [FRAME-1:0] sreg;

  function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SERIAL_SEQ_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= '0;
      sreg <= '0;
    end else if (load) begin
      pat  <= data;
      sreg <= frame_of(data) << 1;
    end else if (reload) begin
      sreg <= frame_of(pat) << 1;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign pat_msb = pat[WIDTH-1];
  assign cur_bit = sreg[FRAME-1];

endmodule

// File: rtl/serial_sequence_generator.sv
// serial_sequence_generator
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB-first,
// reps times (0 treated as 1), with GAP idle cycles between repetitions.
// Optional feature macro: SERIAL_SEQ_PARITY_EN appends an even-parity
// bit to every repetition.
//
// state   | meaning
// S_IDLE  | waiting for start, line at IDLE_LEVEL
// S_SHIFT | a frame bit is on so
// S_GAP   | idle gap between repetitions, still busy
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted only while idle
//   data     : pattern word, latched on accepted start
//   reps     : repetition count, latched on accepted start
//   so       : registered serial output
//   so_valid : so carries a data or parity bit
//   busy     : transmission in progress
//   done     : one-cycle pulse after the final bit
module serial_sequence_generator
  import serial_seq_pkg::*;
#(
  parameter int   WIDTH      = 3,
  parameter int   GAP        = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  data,
  input  logic [REPS_W-1:0] reps,
  output logic              so,
  output logic              so_valid,
  output logic              busy,
  output logic              done
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int BIT_W = cnt_w(WIDTH + 1);
  localparam int GAP_W = cnt_w(GAP + 1);

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [REPS_W-1:0] rep_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic load, reload, shift;
  logic last_bit, last_rep;
  logic pat_msb, cur_bit;

  assign last_bit = (state == S_SHIFT) && (bit_cnt == BIT_W'(FRAME - 1));
  assign last_rep = (rep_cnt == REPS_W'(1));
  assign load     = (state == S_IDLE) && start;
  // back-to-back repetitions restart the frame directly from SHIFT
  assign reload   = (last_bit && !last_rep && (GAP == 0)) ||
                    ((state == S_GAP) && (gap_cnt == '0));
  assign shift    = (state == S_SHIFT) && !last_bit;

  serial_seq_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .reload  (reload),
    .shift   (shift),
    .data    (data),
    .pat_msb (pat_msb),
    .cur_bit (cur_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      gap_cnt  <= '0;
      so       <= IDLE_LEVEL;
      so_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // first bit goes out straight from the input word
            rep_cnt  <= (reps == '0) ? REPS_W'(1) : reps;
            bit_cnt  <= '0;
            so       <= data[WIDTH-1];
            so_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            rep_cnt <= rep_cnt - 1'b1;
            bit_cnt <= '0;
            if (last_rep) begin
              state    <= S_IDLE;
              so       <= IDLE_LEVEL;
              so_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (GAP > 0) begin
              state    <= S_GAP;
              gap_cnt  <= GAP_W'(GAP - 1);
              so       <= IDLE_LEVEL;
              so_valid <= 1'b0;
            end else begin
              so <= pat_msb;
            end
          end else begin
            so      <= cur_bit;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state    <= S_SHIFT;
            so       <= pat_msb;
            so_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sequence_generator.sv
module tb_serial_sequence_generator;

  localparam int   WIDTH      = 3;
  localparam int   GAP        = 1;
  localparam logic IDLE_LEVEL = 1'b0;

`ifdef SERIAL_SEQ_PARITY_EN
  localparam int   FRAME      = WIDTH + 1;
  localparam logic [15:0] EXP_101   = 16'b1010;
  localparam logic [15:0] EXP_110X3 = 16'b110011001100;
  localparam logic [15:0] EXP_100   = 16'b1001;
`else
  localparam int   FRAME      = WIDTH;
  localparam logic [15:0] EXP_101   = 16'b101;
  localparam logic [15:0] EXP_110X3 = 16'b110110110;
  localparam logic [15:0] EXP_100   = 16'b100;
`endif
  localparam int LAT1 = FRAME + 1;
  localparam int LAT3 = 3 * FRAME + 2 * GAP + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data;
  logic [7:0]       reps;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  serial_sequence_generator #(
    .WIDTH      (WIDTH),
    .GAP        (GAP),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data     (data),
    .reps     (reps),
    .so       (so),
    .so_valid (so_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on acceptance the whole expected line activity is expanded
  // into a per-cycle queue; done follows the last entry.
  typedef struct {
    logic so;
    logic v;
  } item_t;

  item_t q[$];
  item_t it;
  logic  m_so, m_v, m_busy, m_done;

  task automatic build(input logic [WIDTH-1:0] d, input logic [7:0] r);
    int n;
    item_t e;
    n = (r == 8'd0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        e.so = d[i];
        e.v  = 1'b1;
        q.push_back(e);
      end
`ifdef SERIAL_SEQ_PARITY_EN
      e.so = ^d;
      e.v  = 1'b1;
      q.push_back(e);
`endif
      if (k < n - 1) begin
        for (int g = 0; g < GAP; g++) begin
          e.so = IDLE_LEVEL;
          e.v  = 1'b0;
          q.push_back(e);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_so = IDLE_LEVEL; m_v = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      if (!m_busy && start) build(data, reps);
      if (q.size() > 0) begin
        it = q.pop_front();
        m_so = it.so; m_v = it.v; m_busy = 1'b1; m_done = 1'b0;
      end else begin
        m_done = m_busy;
        m_so = IDLE_LEVEL; m_v = 1'b0; m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("so", 32'(so), 32'(m_so));
      chk("so_valid", 32'(so_valid), 32'(m_v));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
    end
  end

  logic cap[$];
  always @(negedge clk) if (so_valid === 1'b1) cap.push_back(so);

  function automatic logic [15:0] cap_word();
    logic [15:0] w;
    w = '0;
    foreach (cap[i]) w = {w[14:0], cap[i]};
    return w;
  endfunction

  function automatic int count_110();
    int c;
    c = 0;
    for (int i = 0; i + 2 < cap.size(); i++)
      if (cap[i] && cap[i+1] && !cap[i+2]) c++;
    return c;
  endfunction

  // Starts a stream and returns the cycle number of done (-1 if none).
  // poke: a foreign start with data 011 lands mid-stream.
  // abort_cyc>0: rst asserted during that cycle.
  task automatic run(input logic [WIDTH-1:0] d, input logic [7:0] r,
                     input bit poke, input int abort_cyc, output int lat);
    @(posedge clk); #2;
    start = 1'b1; data = d; reps = r;
    cap.delete();
    @(posedge clk); #2;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (poke && n == 1) begin start = 1'b1; data = WIDTH'(3'b011); end
      if (poke && n == 2) start = 1'b0;
      if (abort_cyc > 0 && n == abort_cyc) rst = 1'b1;
      if (abort_cyc > 0 && n == abort_cyc + 1) begin
        chk("abort_so", 32'(so), 32'(IDLE_LEVEL));
        chk("abort_valid", 32'(so_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
      end
    end
  endtask

  int lat;

  initial begin
    rst = 1'b1; start = 1'b0; data = '0; reps = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    chk("reset_so", 32'(so), 32'd0);
    chk("reset_valid", 32'(so_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    run(3'b101, 8'd1, 1'b0, 0, lat);
    chk("s101_lat", 32'(lat), 32'(LAT1));
    chk("s101_bits", 32'(cap_word()), 32'(EXP_101));
    chk("s101_n", 32'(cap.size()), 32'(FRAME));

    run(3'b110, 8'd3, 1'b0, 0, lat);
    chk("s110x3_lat", 32'(lat), 32'(LAT3));
    chk("s110x3_bits", 32'(cap_word()), 32'(EXP_110X3));
    chk("s110x3_n", 32'(cap.size()), 32'(3 * FRAME));
    chk("s110x3_hits", 32'(count_110()), 32'd3);

    run(3'b110, 8'd3, 1'b1, 0, lat);
    chk("ignore_lat", 32'(lat), 32'(LAT3));
    chk("ignore_bits", 32'(cap_word()), 32'(EXP_110X3));

    run(3'b101, 8'd0, 1'b0, 0, lat);
    chk("reps0_lat", 32'(lat), 32'(LAT1));
    chk("reps0_bits", 32'(cap_word()), 32'(EXP_101));

    run(3'b110, 8'd3, 1'b0, 2, lat);
    chk("abort_no_done", 32'(lat), 32'hFFFF_FFFF);

    run(3'b110, 8'd3, 1'b0, 0, lat);
    chk("fresh_lat", 32'(lat), 32'(LAT3));
    chk("fresh_bits", 32'(cap_word()), 32'(EXP_110X3));

    run(3'b100, 8'd1, 1'b0, 0, lat);
    chk("s100_lat", 32'(lat), 32'(LAT1));
    chk("s100_bits", 32'(cap_word()), 32'(EXP_100));

    // back-to-back start in the done cycle
    @(posedge clk); #2;
    start = 1'b1; data = 3'b101; reps = 8'd1;
    cap.delete();
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    for (int n = 1; n <= 3 * FRAME; n++) @(negedge clk);
    start = 1'b0;
    repeat (2 * FRAME + 4) @(negedge clk);
    chk("b2b_n", 32'(cap.size()), 32'(4 * FRAME));

    // reset held two cycles while idle
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_rst_so", 32'(so), 32'd0);
    chk("idle_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
